fp_wb_arbiter: RTL

//   Write-port arbiter and scoreboard for the 32-entry FP register file.

---
 rtl/fp_pkg.sv | 15 +
 rtl/fp_wb_arbiter_rr.sv | 41 ++++
 rtl/fp_wb_arbiter.sv | 124 ++++++++++++
 3 files changed

// File: rtl/fp_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fp_pkg
// Brief    : Shared FP register-file constants and register-index type.
// Revision : 1.0 - initial release
// ============================================================================
package fp_pkg;

  localparam int FP_NREG   = 32;
  localparam int FP_RIDX_W = 5;

  typedef logic [FP_RIDX_W-1:0] fp_ridx_t;

endpackage
`default_nettype wire

// File: rtl/fp_wb_arbiter_rr.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter
// Brief    : Combinational round-robin arbiter. The search starts at ptr and
//            wraps modulo N; the first asserted request wins.
// Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx
);

  // Rotating priority search: the first valid request at or after ptr wins.
  always_comb begin
    int            w_sum;
    logic [IW-1:0] w_idx;
    logic          w_found;
    gnt     = '0;
    gnt_idx = '0;
    w_found = 1'b0;
    w_sum   = 0;
    w_idx   = '0;
    for (int k = 0; k < N; k++) begin
      w_sum = int'(ptr) + k;
      if (w_sum >= N) w_sum = w_sum - N;
      w_idx = IW'(w_sum);
      if (!w_found && req[w_idx]) begin
        w_found    = 1'b1;
        gnt[w_idx] = 1'b1;
        gnt_idx    = w_idx;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/fp_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : fp_wb_arbiter
// Brief    : Round-robin arbiter for the FP register-file write port. It also
//            keeps a busy scoreboard of in-flight destinations and stalls
//            issue on a WAW conflict.
// Revision : 1.0 - initial release
// ============================================================================
module fp_wb_arbiter
  import fp_pkg::*;
#(
  parameter int FLEN = 32,
  parameter int NREQ = 4
) (
  input  logic                      CLK,
  input  logic                      rst,
  input  logic [NREQ-1:0]           req_valid,
  input  logic [FP_RIDX_W*NREQ-1:0] req_rd,
  input  logic [FLEN*NREQ-1:0]      req_data,
  output logic [NREQ-1:0]           req_ready,
  input  logic                      issue_valid,
  input  logic [FP_RIDX_W-1:0]      issue_rd,
  output logic                      issue_stall,
  output logic [FP_NREG-1:0]        busy,
  output logic                      Reg_Wr,
  output logic [FP_RIDX_W-1:0]      Rd_Wr,
  output logic [FLEN-1:0]           Rd_In,
  output logic                      err_unexp
);

  localparam int PW = $clog2(NREQ);
  localparam logic [PW-1:0] C_LAST = PW'(NREQ - 1);

  logic [PW-1:0]      r_rr_ptr;
  logic [NREQ-1:0]    w_gnt;
  logic [PW-1:0]      w_gnt_idx;
  fp_ridx_t           w_gnt_rd;
  logic [FLEN-1:0]    w_gnt_data;
  logic               w_xfer;
  logic               w_issue_ok;
  logic [FP_NREG-1:0] r_busy;
  logic [FP_NREG-1:0] w_busy_next;
  logic               r_reg_wr;
  fp_ridx_t           r_rd_wr;
  logic [FLEN-1:0]    r_rd_in;
  logic               r_err;

  rr_arbiter #(
    .N  (NREQ),
    .IW (PW)
  ) u_rr (
    .req     (req_valid),
    .ptr     (r_rr_ptr),
    .gnt     (w_gnt),
    .gnt_idx (w_gnt_idx)
  );

  assign req_ready   = w_gnt;
  assign w_xfer      = |(w_gnt & req_valid);
  assign issue_stall = issue_valid & r_busy[issue_rd];
  assign w_issue_ok  = issue_valid & ~r_busy[issue_rd];
  assign busy        = r_busy;
  assign Reg_Wr      = r_reg_wr;
  assign Rd_Wr       = r_rd_wr;
  assign Rd_In       = r_rd_in;
  assign err_unexp   = r_err;

  // One-hot select of the granted requester's destination and data.
  always_comb begin
    w_gnt_rd   = '0;
    w_gnt_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_gnt[i]) begin
        w_gnt_rd   = w_gnt_rd   | req_rd[FP_RIDX_W*i +: FP_RIDX_W];
        w_gnt_data = w_gnt_data | req_data[FLEN*i +: FLEN];
      end
    end
  end

  // Scoreboard next state: clear the retiring write first so a same-edge set wins.
  always_comb begin
    w_busy_next = r_busy;
    if (r_reg_wr)   w_busy_next[r_rd_wr]  = 1'b0;
    if (w_issue_ok) w_busy_next[issue_rd] = 1'b1;
  end

  // Round-robin pointer moves just past the requester that transferred.
  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      r_rr_ptr <= '0;
    end else if (w_xfer) begin
      r_rr_ptr <= (w_gnt_idx == C_LAST) ? '0 : w_gnt_idx + 1'b1;
    end
  end

  // Write-back register: one-cycle latency; address and data hold when idle.
  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      r_reg_wr <= 1'b0;
      r_rd_wr  <= '0;
      r_rd_in  <= '0;
    end else begin
      r_reg_wr <= w_xfer;
      if (w_xfer) begin
        r_rd_wr <= w_gnt_rd;
        r_rd_in <= w_gnt_data;
      end
    end
  end

  // Busy scoreboard register.
  always_ff @(posedge CLK or posedge rst) begin
    if (rst) r_busy <= '0;
    else     r_busy <= w_busy_next;
  end

  // Sticky flag for a write-back to a destination nobody was waiting on.
  always_ff @(posedge CLK or posedge rst) begin
    if (rst)                           r_err <= 1'b0;
    else if (w_xfer && !r_busy[w_gnt_rd]) r_err <= 1'b1;
  end

endmodule
`default_nettype wire
